m_seq_gen: RTL and testbench
============================

Name: m_seq_gen

Overview:
Parametrised maximal-length (m-sequence) PN chip generator for the digital modulator datapath.
- Fibonacci LFSR of configurable length and tap polynomial.
- Advances on an internal clock-enable tick from a programmable divider. No derived clocks: everything runs on `clk`.
- Adds runtime seed loading, enable/hold, all-zero lock-up recovery, period-start marker and chip index for downstream modulators and frame alignment.

Parameters:
- `N`, 3, LFSR length in bits (legal 2..16); sequence period is 2^N-1 for primitive taps.
- `TAPS`, 3'b101, N-bit feedback mask; bit i set puts `state[i]` in the XOR; `TAPS[N-1]` must be 1.
- `INIT`, 3'b001, N-bit non-zero state used after reset and for lock-up recovery.
- `DIV`, 100000, `clk` cycles per chip (legal >= 1); 100000 gives 500 Hz chips from a 50 MHz `clk`.

Ports:
- `clk`, in, 1, system clock.
- `reset`, in, 1, asynchronous, active-high reset.
- `enable`, in, 1, run when high; divider and LFSR hold when low.
- `seed_load`, in, 1, single-cycle request to load `seed`.
- `seed`, in, N, new LFSR state and new period reference.
- `ser_out`, out, 1, PN chip; registered, held between ticks.
- `chip_stb`, out, 1, one-cycle pulse in the cycle `ser_out` updates.
- `period_start`, out, 1, qualifies `chip_stb`: this chip is the first of a period.
- `chip_idx`, out, N, index of the current chip within the period, 0..2^N-2.
- `state_out`, out, N, current LFSR state.
- `lockup`, out, 1, one-cycle pulse when an all-zero state is replaced by `INIT`.

Behaviour:
- Reset (async, any time, including mid-period):
  - `state` = `INIT`, `ref` = `INIT`, divider count = 0.
  - `ser_out`, `chip_stb`, `period_start`, `lockup` = 0; `chip_idx` = 0.
- Divider:
  - `cnt` counts 0..DIV-1 while `enable` is high; `tick` = `enable` && `cnt` == DIV-1; `cnt` wraps to 0 on `tick`.
  - `enable` low: `cnt` holds and no ticks occur. With `DIV`=1, `tick` = `enable`.
- On `tick` (no `seed_load`), with fb = XOR-reduce(`state` & `TAPS`):
  - `ser_out` <= `state[N-1]`.
  - `state` <= {`state[N-2:0]`, fb}.
  - `chip_stb` <= 1.
  - `period_start` <= (`state` == `ref`).
  - `chip_idx` <= 0 if `state` == `ref`, else `chip_idx`+1.
- Latency: `ser_out`, `chip_stb`, `period_start` and `chip_idx` all update in the cycle after `tick`. `chip_stb` is 0 in every other cycle.
- Lock-up:
  - If `state` == 0 at `tick`: `state` <= `INIT`, `ser_out` <= 0, `chip_stb` <= 1, `lockup` <= 1, `period_start` <= 0.
  - This is reachable only via a non-primitive `TAPS`.
- `seed_load`:
  - Has priority over a coincident `tick`; that tick is discarded.
  - `state` <= `seed`, `ref` <= `seed`, `cnt` <= 0, `chip_idx` <= 0, `chip_stb` <= 0. `ser_out` holds.
  - If `seed` == 0: load `INIT` into both `state` and `ref` instead, and pulse `lockup`.
  - Accepted regardless of `enable`.
- `state_out` mirrors the `state` register directly.
- `chip_idx` arithmetic is N-bit unsigned and never exceeds 2^N-2 for primitive taps. Otherwise it wraps modulo 2^N.
- Back-to-back `seed_load` cycles: the last one wins.

Decomposition:
- Package `m_seq_pkg`:
  - Constants: table of primitive tap masks for N=3..16 (e.g. `TAPS_3`=101, `TAPS_7`=1100000, `TAPS_15`=110000000000000).
  - Function `lfsr_next(state, taps)`.
- Sub-module `m_seq_tick`: parametrised divider producing `tick` from `enable`, with a synchronous clear input driven by `seed_load`.

Test Plan:
1. Defaults with `DIV`=4, `enable`=1 after reset: `chip_stb` fires every 4 `clk`.
   - `ser_out` is 0,0,1,1,1,0,1 repeating.
   - `state_out` is 001→011→111→110→101→010→100→001.
   - `period_start` is high on every 7th `chip_stb`, when `chip_idx` = 0.
2. Drop `enable` for 10 cycles mid-count, then restore: no `chip_stb` while low. The next strobe arrives after the remaining count resumes, and the sequence continues unbroken.
3. Assert `seed_load` with `seed`=3'b110 in the same cycle as a `tick`:
   - No strobe in the following cycle.
   - `state_out`=110, `chip_idx`=0.
   - The first strobe, after 4 clk, gives `ser_out`=1 with `period_start`=1.
4. `seed_load` with `seed`=0: `state_out`=001, `lockup` pulses for one cycle, and the sequence restarts as in test 1.
5. `N`=7, `TAPS`=7'b1100000, `DIV`=1: exactly 127 strobes between consecutive `period_start` pulses, and `chip_idx` runs 0..126.
6. Assert `reset` asynchronously between clock edges mid-sequence: all outputs are zero immediately and `state_out`=`INIT`. After release the sequence restarts from the test-1 start.

Source files
------------

// File: rtl/m_seq_pkg.sv
// Shared constants and LFSR helper for the m-sequence PN generator.
// Tap masks use bit i = state[i] in the feedback XOR; all are primitive.
package m_seq_pkg;

  localparam logic [2:0]  TAPS_3  = 3'b101;
  localparam logic [3:0]  TAPS_4  = 4'b1100;
  localparam logic [4:0]  TAPS_5  = 5'b10100;
  localparam logic [5:0]  TAPS_6  = 6'b110000;
  localparam logic [6:0]  TAPS_7  = 7'b1100000;
  localparam logic [7:0]  TAPS_8  = 8'b10111000;
  localparam logic [8:0]  TAPS_9  = 9'b100010000;
  localparam logic [9:0]  TAPS_10 = 10'b1001000000;
  localparam logic [10:0] TAPS_11 = 11'b10100000000;
  localparam logic [11:0] TAPS_12 = 12'b100000101001;
  localparam logic [12:0] TAPS_13 = 13'b1000000001101;
  localparam logic [13:0] TAPS_14 = 14'b10000000010101;
  localparam logic [14:0] TAPS_15 = 15'b110000000000000;
  localparam logic [15:0] TAPS_16 = 16'b1101000000001000;

  // Fibonacci step on a zero-extended state; callers truncate to their own N.
  function automatic logic [15:0] lfsr_next(input logic [15:0] state,
                                            input logic [15:0] taps);
    return {state[14:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/m_seq_tick.sv
// Chip-rate divider: one-cycle tick every DIV enabled clk cycles.
module m_seq_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/m_seq_gen.sv
// Maximal-length PN chip generator with seed load, lock-up recovery,
// period-start marker and chip index; everything runs on clk.
module m_seq_gen
  import m_seq_pkg::*;
#(
  parameter int             N    = 3,
  parameter logic [N-1:0]   TAPS = N'(TAPS_3),
  parameter logic [N-1:0]   INIT = N'(1),
  parameter int             DIV  = 100000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         seed_load,
  input  logic [N-1:0] seed,
  output logic         ser_out,
  output logic         chip_stb,
  output logic         period_start,
  output logic [N-1:0] chip_idx,
  output logic [N-1:0] state_out,
  output logic         lockup
);

  logic         tick;
  logic [N-1:0] state_q;
  logic [N-1:0] ref_q;
  logic [N-1:0] state_nx;
  logic         at_ref;

  m_seq_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clr    (seed_load),
    .tick   (tick)
  );

  assign state_nx  = N'(lfsr_next(16'(state_q), 16'(TAPS)));
  assign at_ref    = (state_q == ref_q);
  assign state_out = state_q;

  // A seed load discards any coincident tick; a zero seed falls back to INIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= INIT;
      ref_q        <= INIT;
      ser_out      <= 1'b0;
      chip_stb     <= 1'b0;
      period_start <= 1'b0;
      chip_idx     <= '0;
      lockup       <= 1'b0;
    end else begin
      chip_stb     <= 1'b0;
      period_start <= 1'b0;
      lockup       <= 1'b0;
      if (seed_load) begin
        chip_idx <= '0;
        if (seed == '0) begin
          state_q <= INIT;
          ref_q   <= INIT;
          lockup  <= 1'b1;
        end else begin
          state_q <= seed;
          ref_q   <= seed;
        end
      end else if (tick) begin
        chip_stb <= 1'b1;
        if (state_q == '0) begin
          state_q <= INIT;
          ser_out <= 1'b0;
          lockup  <= 1'b1;
        end else begin
          ser_out      <= state_q[N-1];
          state_q      <= state_nx;
          period_start <= at_ref;
          chip_idx     <= at_ref ? '0 : chip_idx + N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_m_seq_gen.sv
// Directed bench for m_seq_gen: default 3-bit generator at DIV=4 plus a
// 7-bit, DIV=1 instance for the full-period check.
module tb_m_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       seed_load = 1'b0;
  logic [2:0] seed = 3'b000;
  logic       ser_out, chip_stb, period_start, lockup;
  logic [2:0] chip_idx, state_out;

  logic       enable7 = 1'b0;
  logic       seed_load7 = 1'b0;
  logic [6:0] seed7 = 7'd0;
  logic       ser7, stb7, ps7, lock7;
  logic [6:0] idx7, st7;

  int checks = 0;
  int errors = 0;

  logic [2:0] st_tab [7];
  logic       ser_tab [7];

  always #5 clk = ~clk;

  m_seq_gen #(.N(3), .TAPS(3'b101), .INIT(3'b001), .DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed(seed), .ser_out(ser_out), .chip_stb(chip_stb),
    .period_start(period_start), .chip_idx(chip_idx),
    .state_out(state_out), .lockup(lockup)
  );

  m_seq_gen #(.N(7), .TAPS(7'b1100000), .INIT(7'd1), .DIV(1)) dut7 (
    .clk(clk), .reset(reset), .enable(enable7), .seed_load(seed_load7),
    .seed(seed7), .ser_out(ser7), .chip_stb(stb7),
    .period_start(ps7), .chip_idx(idx7),
    .state_out(st7), .lockup(lock7)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // quiet non-strobe cycles, then one strobe carrying chip 'phase' of the base table
  task automatic check_chip(input int quiet, input int phase, input int idx, input int ps);
    for (int q = 0; q < quiet; q++) begin
      step();
      chk("stb_quiet", 32'(chip_stb), 32'd0);
    end
    step();
    chk("stb", 32'(chip_stb), 32'd1);
    chk("ser", 32'(ser_out), 32'(ser_tab[phase]));
    chk("state", 32'(state_out), 32'(st_tab[(phase + 1) % 7]));
    chk("idx", 32'(chip_idx), 32'(idx));
    chk("pstart", 32'(period_start), 32'(ps));
  endtask

  initial begin
    st_tab  = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b101, 3'b010, 3'b100};
    ser_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_ser", 32'(ser_out), 32'd0);
    chk("rst_stb", 32'(chip_stb), 32'd0);
    chk("rst_ps", 32'(period_start), 32'd0);
    chk("rst_idx", 32'(chip_idx), 32'd0);
    chk("rst_state", 32'(state_out), 32'd1);
    chk("rst_lock", 32'(lockup), 32'd0);
    step();
    step();
    reset = 1'b0;
    enable = 1'b1;

    // free-running sequence, two full periods
    for (int c = 0; c < 14; c++) check_chip(3, c % 7, c % 7, (c % 7 == 0) ? 1 : 0);

    // enable hold mid-count
    step();
    step();
    enable = 1'b0;
    for (int h = 0; h < 10; h++) begin
      step();
      chk("hold_stb", 32'(chip_stb), 32'd0);
    end
    chk("hold_state", 32'(state_out), 32'd1);
    enable = 1'b1;
    check_chip(1, 0, 0, 1);
    check_chip(3, 1, 1, 0);

    // seed load coincident with a tick
    for (int q = 0; q < 3; q++) step();
    seed = 3'b110;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("seed_stb", 32'(chip_stb), 32'd0);
    chk("seed_state", 32'(state_out), 32'b110);
    chk("seed_idx", 32'(chip_idx), 32'd0);
    chk("seed_ser_hold", 32'(ser_out), 32'd0);
    check_chip(3, 3, 0, 1);
    check_chip(3, 4, 1, 0);
    check_chip(3, 5, 2, 0);

    // zero seed falls back to INIT with a lockup pulse
    seed = 3'b000;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    chk("zseed_state", 32'(state_out), 32'd1);
    chk("zseed_lock", 32'(lockup), 32'd1);
    chk("zseed_idx", 32'(chip_idx), 32'd0);
    chk("zseed_stb", 32'(chip_stb), 32'd0);
    step();
    chk("zseed_lock_end", 32'(lockup), 32'd0);
    chk("zseed_stb2", 32'(chip_stb), 32'd0);
    check_chip(2, 0, 0, 1);
    check_chip(3, 1, 1, 0);
    check_chip(3, 2, 2, 0);

    // asynchronous reset between edges
    step();
    #3 reset = 1'b1;
    #1;
    chk("arst_ser", 32'(ser_out), 32'd0);
    chk("arst_stb", 32'(chip_stb), 32'd0);
    chk("arst_ps", 32'(period_start), 32'd0);
    chk("arst_idx", 32'(chip_idx), 32'd0);
    chk("arst_state", 32'(state_out), 32'd1);
    chk("arst_lock", 32'(lockup), 32'd0);
    step();
    step();
    reset = 1'b0;
    check_chip(3, 0, 0, 1);
    check_chip(3, 1, 1, 0);

    // 7-bit generator at one chip per clk: full 127-chip period
    enable7 = 1'b1;
    for (int k = 0; k < 255; k++) begin
      step();
      chk("n7_stb", 32'(stb7), 32'd1);
      chk("n7_idx", 32'(idx7), 32'(k % 127));
      chk("n7_ps", 32'(ps7), 32'((k % 127) == 0));
      chk("n7_lock", 32'(lock7), 32'd0);
    end
    chk("n7_state_wrap", 32'(st7), 32'd2);
    enable7 = 1'b0;
    step();
    chk("n7_off_stb", 32'(stb7), 32'd0);
    step();
    chk("n7_off_idx", 32'(idx7), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
